md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multiply/divide execution unit. It consumes the mult/div requests and operands issued by decode, and returns the 64-bit {HI,LO} result with a one-cycle completion pulse that decode uses to update its HI/LO registers.
- MULT/MULTU complete after a fixed pipeline latency. DIV/DIVU use an iterative 32-step restoring divider.
- A busy flag lets decode stall dependent instructions. A cancel input lets exception/ERET flush an in-flight operation.

Parameters:
- MUL_LAT, 2, cycles from request acceptance to md_complete for multiply; legal range 1..4.
- DIV_STEPS, 32, restoring-divide iterations; fixed by 32-bit operands, not to be overridden.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- md_mult_en  in  1  start multiply (MULT/MULTU).
- md_div_en  in  1  start divide (DIV/DIVU).
- md_is_signed  in  1  1 = signed (MULT/DIV), 0 = unsigned.
- md_src1  in  32  rs operand; multiplicand or dividend.
- md_src2  in  32  rt operand; multiplier or divisor.
- md_cancel  in  1  abort the in-flight operation (exception flush).
- md_busy  out  1  operation in flight; new requests are ignored.
- md_complete  out  1  one-cycle pulse; md_result valid.
- md_result  out  64  {HI,LO}. Multiply: full product. Divide: {remainder, quotient}.

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE; md_busy=0, md_complete=0, md_result=0; counter and datapath registers cleared.
  - Deassertion is sampled synchronously.
- States: IDLE, MUL, DIV, DONE.
- Acceptance: in IDLE or DONE, a rising edge T with md_mult_en|md_div_en=1 latches the operands and md_is_signed, and sets md_busy=1.
  - If both enables are high, multiply wins and div_en is dropped.
  - Requests in MUL or DIV are ignored; no queueing.
- Multiply:
  - Product = 64-bit signed or unsigned product of src1×src2.
  - Counter runs MUL_LAT edges. State goes DONE at edge T+MUL_LAT.
- Divide:
  - Edge T latches |src1| and |src2| (absolute values if signed, raw if unsigned) and the two sign bits.
  - Edges T+1..T+32: one restoring step each, MSB first. Remainder register is 33 bits.
  - Edge T+33: sign fix and state goes DONE.
    - Quotient is negated iff signed and the sign bits differ.
    - Remainder takes the dividend's sign; truncation is toward zero.
- Divide by zero:
  - Unsigned: quotient=0xFFFFFFFF, remainder=src1.
  - Signed: magnitude results as above (quotient 0xFFFFFFFF, remainder |src1|), then the normal sign fix, with divisor sign taken as 0.
  - 0x80000000 / 0xFFFFFFFF signed yields quotient 0x80000000, remainder 0.
- DONE state:
  - md_complete=1 and md_busy=0 for exactly one cycle; md_result is updated on the same edge.
  - md_result holds until the next completion; it is not cleared by idle or cancel.
  - Next state is IDLE, unless a new request is accepted in that cycle (back-to-back allowed).
- Cancel:
  - md_cancel=1 while in MUL or DIV forces IDLE on the next edge: md_busy=0, no md_complete, md_result unchanged.
  - Cancel in IDLE or DONE has no effect on a completion already being presented.
  - Cancel and a new request in the same IDLE cycle: cancel wins and the request is dropped.
- md_busy equals (state==MUL || state==DIV).

Optional Feature:
- MD_DIVZERO_FAST_EN.
  - Defined: a divide with src2==0 skips the iterations and enters DONE at edge T+1, with the divide-by-zero values above.
  - Undefined: divide by zero runs the full 33-cycle sequence and produces the identical values via the normal datapath.

Test Plan:
- MULT signed, src1=0xFFFFFFFE, src2=3 → md_complete at edge T+2, md_result=0xFFFFFFFF_FFFFFFFA, md_busy high for edges T..T+1.
- MULTU, src1=src2=0xFFFFFFFF → md_result=0xFFFFFFFE_00000001; a DIVU request during MUL is ignored (no second completion).
- DIV signed, src1=-7 (0xFFFFFFF9), src2=2 → complete at T+33, md_result=0xFFFFFFFF_FFFFFFFD (HI=-1, LO=-3).
- DIVU, src1=100, src2=0 → md_result=0x00000064_FFFFFFFF; complete at T+33, or at T+1 with MD_DIVZERO_FAST_EN.
- DIVU 1000/7 with md_cancel at T+10 → md_busy low at T+11, no md_complete, md_result keeps its prior value. A following MULTU 6×7 → md_result=0x00000000_0000002A.
- resetn low at T+5 of a divide → md_busy, md_complete and md_result go 0 immediately (asynchronous). After release, a DIVU 9/3 → md_result=0x00000000_00000003.

Source files
------------

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multiply/divide unit: fixed-latency multiply, 32-step restoring divide (option: MD_DIVZERO_FAST_EN)
module md_unit #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        md_mult_en,
    input  logic        md_div_en,
    input  logic        md_is_signed,
    input  logic [31:0] md_src1,
    input  logic [31:0] md_src2,
    input  logic        md_cancel,
    output logic        md_busy,
    output logic        md_complete,
    output logic [63:0] md_result
);

    localparam int DIV_STEPS = 32;
    localparam logic [5:0] MUL_LAST = 6'(MUL_LAT);
    localparam logic [5:0] DIV_LAST = 6'(DIV_STEPS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t      state;
    logic [5:0]  cnt;
    // Multiply: raw operands. Divide: op_a shifts dividend out and quotient in, op_b is |divisor|.
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] rem;
    logic        op_signed;
    logic        neg_q;
    logic        neg_r;

    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;
    logic [32:0] trial;
    logic        fits;
    logic [31:0] diff;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign abs_a = (md_is_signed && md_src1[31]) ? (~md_src1 + 32'd1) : md_src1;
    assign abs_b = (md_is_signed && md_src2[31]) ? (~md_src2 + 32'd1) : md_src2;

    // Sign-extending to 64 bits makes the low 64 bits of a plain product correct for both signednesses.
    assign mul_a   = {{32{op_signed & op_a[31]}}, op_a};
    assign mul_b   = {{32{op_signed & op_b[31]}}, op_b};
    assign product = mul_a * mul_b;

    assign trial = {rem, op_a[31]};
    assign fits  = (trial >= {1'b0, op_b});
    assign diff  = trial[31:0] - op_b;

    assign quo_fix = neg_q ? (~op_a + 32'd1) : op_a;
    assign rem_fix = neg_r ? (~rem + 32'd1) : rem;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            md_busy     <= 1'b0;
            md_complete <= 1'b0;
            md_result   <= '0;
            cnt         <= '0;
            op_a        <= '0;
            op_b        <= '0;
            rem         <= '0;
            op_signed   <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
        end else begin
            md_complete <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE: begin
                    state   <= S_IDLE;
                    md_busy <= 1'b0;
                    if (!md_cancel && md_mult_en) begin
                        state     <= S_MUL;
                        md_busy   <= 1'b1;
                        cnt       <= 6'd1;
                        op_a      <= md_src1;
                        op_b      <= md_src2;
                        op_signed <= md_is_signed;
                    end else if (!md_cancel && md_div_en) begin
                        state     <= S_DIV;
                        md_busy   <= 1'b1;
                        op_b      <= abs_b;
                        op_signed <= md_is_signed;
                        neg_q     <= md_is_signed & (md_src1[31] ^ md_src2[31]);
                        neg_r     <= md_is_signed & md_src1[31];
`ifdef MD_DIVZERO_FAST_EN
                        if (md_src2 == 32'd0) begin
                            cnt  <= DIV_LAST;
                            op_a <= '1;
                            rem  <= abs_a;
                        end else begin
                            cnt  <= '0;
                            op_a <= abs_a;
                            rem  <= '0;
                        end
`else
                        cnt  <= '0;
                        op_a <= abs_a;
                        rem  <= '0;
`endif
                    end
                end
                S_MUL: begin
                    if (md_cancel) begin
                        state   <= S_IDLE;
                        md_busy <= 1'b0;
                    end else if (cnt == MUL_LAST) begin
                        state       <= S_DONE;
                        md_busy     <= 1'b0;
                        md_complete <= 1'b1;
                        md_result   <= product;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                S_DIV: begin
                    if (md_cancel) begin
                        state   <= S_IDLE;
                        md_busy <= 1'b0;
                    end else if (cnt == DIV_LAST) begin
                        state       <= S_DONE;
                        md_busy     <= 1'b0;
                        md_complete <= 1'b1;
                        md_result   <= {rem_fix, quo_fix};
                    end else begin
                        // A zero divisor always "fits", giving all-ones quotient and remainder = dividend.
                        op_a <= {op_a[30:0], fits};
                        rem  <= fits ? diff : trial[31:0];
                        cnt  <= cnt + 6'd1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    md_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - self-checking bench for md_unit: vector table, hand sequences, randomized model check
module tb_md_unit;

`ifdef MD_DIVZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif
    localparam int MLAT = 2;
    localparam int DLAT = 33;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        md_mult_en = 1'b0;
    logic        md_div_en = 1'b0;
    logic        md_is_signed = 1'b0;
    logic [31:0] md_src1 = '0;
    logic [31:0] md_src2 = '0;
    logic        md_cancel = 1'b0;
    logic        md_busy;
    logic        md_complete;
    logic [63:0] md_result;

    int checks = 0;
    int failures = 0;

    md_unit dut (
        .clk(clk),
        .resetn(resetn),
        .md_mult_en(md_mult_en),
        .md_div_en(md_div_en),
        .md_is_signed(md_is_signed),
        .md_src1(md_src1),
        .md_src2(md_src2),
        .md_cancel(md_cancel),
        .md_busy(md_busy),
        .md_complete(md_complete),
        .md_result(md_result)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          mul;
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit mul, input bit div, input bit sgn,
                         input logic [31:0] a, input logic [31:0] b);
        md_mult_en   = mul;
        md_div_en    = div;
        md_is_signed = sgn;
        md_src1      = a;
        md_src2      = b;
        tick();
        md_mult_en = 1'b0;
        md_div_en  = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!md_complete && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_check(input string name, input bit mul, input bit div, input bit sgn,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [63:0] exp, input int exp_lat);
        int lat;
        issue(mul, div, sgn, a, b);
        chk({name, " busy"}, 64'(md_busy), 64'd1);
        wait_done(lat);
        chk({name, " latency"}, 64'(lat), 64'(exp_lat));
        chk({name, " result"}, md_result, exp);
        chk({name, " busy@done"}, 64'(md_busy), 64'd0);
        tick();
        chk({name, " pulse"}, 64'(md_complete), 64'd0);
    endtask

    // Reference: plain integer arithmetic on the architectural values.
    function automatic logic [63:0] model(input bit mul, input bit sgn,
                                          input logic [31:0] a, input logic [31:0] b);
        longint x;
        longint y;
        logic [31:0] q;
        logic [31:0] r;
        x = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        y = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        if (mul) return 64'(x * y);
        if (b == 32'd0) begin
            q = (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
            r = a;
        end else begin
            q = 32'(x / y);
            r = 32'(x % y);
        end
        return {r, q};
    endfunction

    initial begin
        int lat;
        int ncomp;
        logic [63:0] seen;

        vecs[0] = '{1'b1, 1'b1, 32'hFFFF_FFFE, 32'd3,          64'hFFFF_FFFF_FFFF_FFFA, MLAT};
        vecs[1] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, MLAT};
        vecs[2] = '{1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,          64'hFFFF_FFFF_FFFF_FFFD, DLAT};
        vecs[3] = '{1'b0, 1'b0, 32'd100,       32'd0,          64'h0000_0064_FFFF_FFFF, ZLAT};
        vecs[4] = '{1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  64'h0000_0000_8000_0000, DLAT};
        vecs[5] = '{1'b0, 1'b1, 32'd7,         32'hFFFF_FFFE,  64'h0000_0001_FFFF_FFFD, DLAT};
        vecs[6] = '{1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000,  64'h4000_0000_0000_0000, MLAT};
        vecs[7] = '{1'b0, 1'b1, 32'hFFFF_FF9C, 32'd0,          64'hFFFF_FF9C_0000_0001, ZLAT};
        vecs[8] = '{1'b0, 1'b0, 32'd9,         32'd3,          64'h0000_0000_0000_0003, DLAT};
        vecs[9] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'd5,          64'hFFFF_FFFF_FFFF_FFFB, MLAT};

        #2;
        chk("reset busy", 64'(md_busy), 64'd0);
        chk("reset complete", 64'(md_complete), 64'd0);
        chk("reset result", md_result, 64'd0);
        repeat (2) tick();
        resetn = 1'b1;
        tick();
        chk("idle busy", 64'(md_busy), 64'd0);

        for (int i = 0; i < 10; i++)
            run_check($sformatf("vec%0d", i), vecs[i].mul, !vecs[i].mul, vecs[i].sgn,
                      vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

        // DIVU request while a multiply is in flight must be dropped.
        issue(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        md_div_en = 1'b1;
        md_src1   = 32'd50;
        md_src2   = 32'd5;
        tick();
        md_div_en = 1'b0;
        chk("ignore busy", 64'(md_busy), 64'd1);
        ncomp = 0;
        seen  = '0;
        for (int i = 0; i < 40; i++) begin
            if (md_complete) begin
                ncomp++;
                seen = md_result;
            end
            tick();
        end
        chk("ignore completions", 64'(ncomp), 64'd1);
        chk("ignore result", seen, 64'hFFFF_FFFE_0000_0001);

        // Cancel a divide mid-flight.
        issue(1'b0, 1'b1, 1'b0, 32'd1000, 32'd7);
        repeat (10) tick();
        chk("cancel pre busy", 64'(md_busy), 64'd1);
        md_cancel = 1'b1;
        tick();
        md_cancel = 1'b0;
        chk("cancel busy", 64'(md_busy), 64'd0);
        ncomp = 0;
        for (int i = 0; i < 40; i++) begin
            if (md_complete) ncomp++;
            tick();
        end
        chk("cancel completions", 64'(ncomp), 64'd0);
        chk("cancel result held", md_result, 64'hFFFF_FFFE_0000_0001);
        run_check("mul after cancel", 1'b1, 1'b0, 1'b0, 32'd6, 32'd7, 64'h2A, MLAT);

        // Cancel and request together in IDLE: request dropped.
        md_cancel  = 1'b1;
        md_mult_en = 1'b1;
        md_src1    = 32'd2;
        md_src2    = 32'd3;
        tick();
        md_cancel  = 1'b0;
        md_mult_en = 1'b0;
        chk("idle cancel busy", 64'(md_busy), 64'd0);
        ncomp = 0;
        for (int i = 0; i < 5; i++) begin
            if (md_complete) ncomp++;
            tick();
        end
        chk("idle cancel completions", 64'(ncomp), 64'd0);

        // Back-to-back acceptance from DONE.
        issue(1'b1, 1'b0, 1'b0, 32'd3, 32'd4);
        wait_done(lat);
        chk("b2b first result", md_result, 64'd12);
        md_mult_en = 1'b1;
        md_src1    = 32'd5;
        md_src2    = 32'd6;
        tick();
        md_mult_en = 1'b0;
        chk("b2b busy", 64'(md_busy), 64'd1);
        chk("b2b pulse", 64'(md_complete), 64'd0);
        wait_done(lat);
        chk("b2b latency", 64'(lat), 64'(MLAT));
        chk("b2b result", md_result, 64'd30);
        tick();

        // Asynchronous reset during a divide.
        issue(1'b0, 1'b1, 1'b0, 32'h0000_FFFF, 32'd3);
        repeat (5) tick();
        #3;
        resetn = 1'b0;
        #1;
        chk("async busy", 64'(md_busy), 64'd0);
        chk("async complete", 64'(md_complete), 64'd0);
        chk("async result", md_result, 64'd0);
        repeat (2) tick();
        resetn = 1'b1;
        tick();
        run_check("div after reset", 1'b0, 1'b1, 1'b0, 32'd9, 32'd3, 64'd3, DLAT);

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            bit m;
            bit both;
            bit s;
            logic [31:0] a;
            logic [31:0] b;
            m    = 1'($urandom_range(0, 1));
            both = ($urandom_range(0, 7) == 0);
            s    = 1'($urandom_range(0, 1));
            a    = $urandom;
            if ($urandom_range(0, 5) == 0) b = 32'd0;
            else if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
            else b = $urandom;
            if (both) m = 1'b1;
            run_check($sformatf("rnd%0d", i), m, both | !m, s, a, b, model(m, s, a, b),
                      m ? MLAT : ((b == 32'd0) ? ZLAT : DLAT));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
